// File: rtl/int_alu_pipe.sv
// Single-cycle integer ALU feeding a small writeback FIFO with sequence-based kill and a registered branch port.
// Optional macro ALU_BITMANIP_EN adds CLZ/CTZ/CPOP; otherwise those opcodes are illegal.
module int_alu_pipe #(
    parameter int XLEN  = 32,
    parameter int SQN_W = 6,
    parameter int TAG_W = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [SQN_W-1:0] in_sqn,
    input  logic             in_pred_taken,
    input  logic             inv_valid,
    input  logic [SQN_W-1:0] inv_sqn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [SQN_W-1:0] out_sqn,
    output logic             out_exc,
    output logic             br_valid,
    output logic             br_taken,
    output logic             br_mispred,
    output logic [XLEN-1:0]  br_target,
    output logic [SQN_W-1:0] br_sqn
);
    localparam int PW  = $clog2(DEPTH);
    localparam int SHW = $clog2(XLEN);
    localparam logic [PW-1:0]   PTR_ONE = PW'(1);
    localparam logic [XLEN-1:0] PC_INC  = XLEN'(3'd4);

    localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_XOR = 5'd2, OP_OR = 5'd3,
        OP_AND = 5'd4, OP_SLL = 5'd5, OP_SRL = 5'd6, OP_SRA = 5'd7, OP_SLT = 5'd8,
        OP_SLTU = 5'd9, OP_PASSB = 5'd10, OP_BEQ = 5'd11, OP_BNE = 5'd12, OP_BLT = 5'd13,
        OP_BGE = 5'd14, OP_BLTU = 5'd15, OP_BGEU = 5'd16, OP_JAL = 5'd17, OP_JALR = 5'd18,
        OP_CLZ = 5'd19, OP_CTZ = 5'd20, OP_CPOP = 5'd21;

    // Wrapping sequence compare: s is younger than r when (s - r) is strictly positive.
    function automatic logic f_younger(input logic [SQN_W-1:0] s, input logic [SQN_W-1:0] r);
        logic [SQN_W-1:0] d;
        d = s - r;
        return (d != '0) && !d[SQN_W-1];
    endfunction

`ifdef ALU_BITMANIP_EN
    function automatic logic [XLEN-1:0] f_clz(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] n;
        logic            done;
        n = '0;
        done = 1'b0;
        for (int i = XLEN - 1; i >= 0; i--) begin
            if (!done && !v[i]) n = n + XLEN'(1'b1);
            else done = 1'b1;
        end
        return n;
    endfunction

    function automatic logic [XLEN-1:0] f_ctz(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] n;
        logic            done;
        n = '0;
        done = 1'b0;
        for (int i = 0; i < XLEN; i++) begin
            if (!done && !v[i]) n = n + XLEN'(1'b1);
            else done = 1'b1;
        end
        return n;
    endfunction

    function automatic logic [XLEN-1:0] f_cpop(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] n;
        n = '0;
        for (int i = 0; i < XLEN; i++) n = n + XLEN'(v[i]);
        return n;
    endfunction
`endif

    logic [XLEN-1:0]  res_q [DEPTH];
    logic [XLEN-1:0]  res_d [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [TAG_W-1:0] tag_d [DEPTH];
    logic [SQN_W-1:0] sqn_q [DEPTH];
    logic [SQN_W-1:0] sqn_d [DEPTH];
    logic             exc_q [DEPTH];
    logic             exc_d [DEPTH];
    logic             kill_q [DEPTH];
    logic             kill_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             br_valid_q, br_valid_d, br_taken_q, br_taken_d, br_mispred_q, br_mispred_d;
    logic [XLEN-1:0]  br_target_q, br_target_d;
    logic [SQN_W-1:0] br_sqn_q, br_sqn_d;

    logic            accept_s, is_cbr_s, is_br_s, push_s, pop_s, empty_s, alu_exc_s, taken_s;
    logic [XLEN-1:0] alu_res_s, jalr_sum_s;

    // Issue decode and ALU evaluation.
    always_comb begin
        accept_s   = in_valid && in_ready && !(inv_valid && f_younger(in_sqn, inv_sqn));
        is_cbr_s   = (in_op >= OP_BEQ) && (in_op <= OP_BGEU);
        is_br_s    = (in_op >= OP_BEQ) && (in_op <= OP_JALR);
        push_s     = accept_s && !is_cbr_s;
        alu_res_s  = '0;
        alu_exc_s  = 1'b0;
        taken_s    = 1'b0;
        jalr_sum_s = in_a + in_imm;
        case (in_op)
            OP_ADD:   alu_res_s = in_a + in_b;
            OP_SUB:   alu_res_s = in_a - in_b;
            OP_XOR:   alu_res_s = in_a ^ in_b;
            OP_OR:    alu_res_s = in_a | in_b;
            OP_AND:   alu_res_s = in_a & in_b;
            OP_SLL:   alu_res_s = in_a << in_b[SHW-1:0];
            OP_SRL:   alu_res_s = in_a >> in_b[SHW-1:0];
            OP_SRA:   alu_res_s = $unsigned($signed(in_a) >>> in_b[SHW-1:0]);
            OP_SLT:   alu_res_s = XLEN'($signed(in_a) < $signed(in_b));
            OP_SLTU:  alu_res_s = XLEN'(in_a < in_b);
            OP_PASSB: alu_res_s = in_b;
            OP_BEQ:   taken_s = (in_a == in_b);
            OP_BNE:   taken_s = (in_a != in_b);
            OP_BLT:   taken_s = ($signed(in_a) < $signed(in_b));
            OP_BGE:   taken_s = ($signed(in_a) >= $signed(in_b));
            OP_BLTU:  taken_s = (in_a < in_b);
            OP_BGEU:  taken_s = (in_a >= in_b);
            OP_JAL, OP_JALR: begin
                alu_res_s = in_pc + PC_INC;
                taken_s   = 1'b1;
            end
`ifdef ALU_BITMANIP_EN
            OP_CLZ:   alu_res_s = f_clz(in_a);
            OP_CTZ:   alu_res_s = f_ctz(in_a);
            OP_CPOP:  alu_res_s = f_cpop(in_a);
`endif
            default:  alu_exc_s = 1'b1;
        endcase
    end

    // FIFO bookkeeping: push, pop/auto-discard of killed heads, and sequence-based kill marking.
    always_comb begin
        empty_s   = (count_q == '0);
        out_valid = !empty_s && !kill_q[rd_ptr_q];
        pop_s     = !empty_s && (kill_q[rd_ptr_q] || out_ready);
        in_ready  = (count_q != (PW + 1)'(DEPTH));
        wr_ptr_d  = push_s ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d  = pop_s ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (PW + 1)'(1'b1);
            2'b01:   count_d = count_q - (PW + 1)'(1'b1);
            default: count_d = count_q;
        endcase
        for (int i = 0; i < DEPTH; i++) begin
            if (push_s && (wr_ptr_q == PW'(i))) begin
                res_d[i]  = alu_res_s;
                tag_d[i]  = in_tag;
                sqn_d[i]  = in_sqn;
                exc_d[i]  = alu_exc_s;
                kill_d[i] = 1'b0;
            end else begin
                res_d[i]  = res_q[i];
                tag_d[i]  = tag_q[i];
                sqn_d[i]  = sqn_q[i];
                exc_d[i]  = exc_q[i];
                kill_d[i] = kill_q[i] || (inv_valid && f_younger(sqn_q[i], inv_sqn));
            end
        end
        out_result = res_q[rd_ptr_q];
        out_tag    = tag_q[rd_ptr_q];
        out_sqn    = sqn_q[rd_ptr_q];
        out_exc    = exc_q[rd_ptr_q];
    end

    // Branch resolution capture; the pulse is squashed if the very next cycle invalidates it.
    always_comb begin
        br_valid_d = accept_s && is_br_s;
        if (accept_s && is_br_s) begin
            br_taken_d   = taken_s;
            br_mispred_d = (in_op == OP_JALR) || (taken_s != in_pred_taken);
            br_sqn_d     = in_sqn;
            if (in_op == OP_JALR) br_target_d = {jalr_sum_s[XLEN-1:1], 1'b0};
            else if (taken_s) br_target_d = in_imm;
            else br_target_d = in_pc + PC_INC;
        end else begin
            br_taken_d   = br_taken_q;
            br_mispred_d = br_mispred_q;
            br_sqn_d     = br_sqn_q;
            br_target_d  = br_target_q;
        end
        br_valid   = br_valid_q && !(inv_valid && f_younger(br_sqn_q, inv_sqn));
        br_taken   = br_taken_q;
        br_mispred = br_mispred_q;
        br_target  = br_target_q;
        br_sqn     = br_sqn_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            br_valid_q   <= 1'b0;
            br_taken_q   <= 1'b0;
            br_mispred_q <= 1'b0;
            br_target_q  <= '0;
            br_sqn_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                res_q[i]  <= '0;
                tag_q[i]  <= '0;
                sqn_q[i]  <= '0;
                exc_q[i]  <= 1'b0;
                kill_q[i] <= 1'b0;
            end
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            br_valid_q   <= br_valid_d;
            br_taken_q   <= br_taken_d;
            br_mispred_q <= br_mispred_d;
            br_target_q  <= br_target_d;
            br_sqn_q     <= br_sqn_d;
            for (int i = 0; i < DEPTH; i++) begin
                res_q[i]  <= res_d[i];
                tag_q[i]  <= tag_d[i];
                sqn_q[i]  <= sqn_d[i];
                exc_q[i]  <= exc_d[i];
                kill_q[i] <= kill_d[i];
            end
        end
    end
endmodule

// File: doc/int_alu_pipe.md
INT_ALU_PIPE -- requirements
Module: int_alu_pipe

Interface
REQ-001 Parameter XLEN, 32, datapath width in bits; legal values are 32 and 64.
REQ-002 Parameter SQN_W, 6, sequence-number width.
REQ-003 Parameter TAG_W, 6, physical destination tag width.
REQ-004 Parameter DEPTH, 4, result buffer entries; a power of 2, at least 2.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 in_valid/in_ready  in/out  1/1  issue handshake; in_ready = !full, taken from registered state only.
REQ-008 in_op  in  5  opcode: ADD0 SUB1 XOR2 OR3 AND4 SLL5 SRL6 SRA7 SLT8 SLTU9 PASSB10 BEQ11 BNE12 BLT13 BGE14 BLTU15 BGEU16 JAL17 JALR18 CLZ19 CTZ20 CPOP21.
REQ-009 in_a, in_b, in_imm, in_pc  in  XLEN each  operands, immediate, instruction PC.
REQ-010 in_tag/in_sqn/in_pred_taken  in  TAG_W/SQN_W/1  destination tag, sequence number, predicted direction.
REQ-011 inv_valid/inv_sqn  in  1/SQN_W  invalidate every op younger than inv_sqn.
REQ-012 out_valid/out_ready  out/in  1/1  writeback handshake.
REQ-013 out_result/out_tag/out_sqn/out_exc  out  XLEN/TAG_W/SQN_W/1  writeback payload; out_exc flags an illegal opcode.
REQ-014 br_valid/br_taken/br_mispred/br_target/br_sqn  out  1/1/1/XLEN/SQN_W  registered branch resolution.

Function
REQ-015 An op is accepted when in_valid && in_ready, unless inv_valid is high and $signed(in_sqn - inv_sqn) > 0; a rejected op leaves no trace.
REQ-016 Shift ops use in_b[log2(XLEN)-1:0]; SRA is arithmetic; SLT is signed; SLTU is unsigned; results zero-extend to XLEN.
REQ-017 JAL and JALR write in_pc + 4; conditional branches write no result and are not buffered.
REQ-018 Opcodes 22-31 are buffered with result 0 and out_exc = 1.
REQ-019 Accepted result-producing ops are pushed into a DEPTH-entry FIFO holding {result, tag, sqn, exc, kill}; wr/rd pointers wrap modulo DEPTH; count is 0..DEPTH.
REQ-020 Latency is 1 cycle: an op accepted in cycle N into an empty FIFO has out_valid high in cycle N+1.
REQ-021 out_valid = !empty && !head.kill; a pop occurs on out_valid && out_ready; payload is held stable while out_valid is high and out_ready is low.
REQ-022 An entry at the head with kill set is discarded automatically, one per cycle, without asserting out_valid.
REQ-023 On inv_valid, every resident entry with $signed(sqn - inv_sqn) > 0 has kill set in the same edge; older and equal entries are untouched.
REQ-024 A simultaneous push and pop in one cycle leaves count unchanged; when full, in_ready is low even if out_ready is high.
REQ-025 Branch ops (BEQ..JALR) register br_* one cycle after acceptance, independent of out_ready; br_valid is a single-cycle pulse.
REQ-026 br_taken is 1 for JAL and JALR and the comparison result for BEQ..BGEU; br_mispred = br_taken != in_pred_taken, forced to 1 for JALR.
REQ-027 br_target is in_imm when taken (JAL, conditional branches), (in_a + in_imm) & ~1 for JALR, and in_pc + 4 when not taken.
REQ-028 br_valid for an op accepted in cycle N is suppressed if inv_valid in cycle N+1 marks its sqn younger.

Reset
REQ-029 On rst: pointers and count = 0; out_valid = 0; br_valid, br_taken and br_mispred = 0; out_result, out_tag, out_sqn, out_exc, br_target and br_sqn = 0.
REQ-030 rst asserted mid-operation discards all buffered entries and any pending branch pulse in the same edge; in_ready is 1 in the cycle after rst deasserts.

Configuration
REQ-031 Macro ALU_BITMANIP_EN defined: CLZ, CTZ and CPOP return counts (0..XLEN) of in_a, zero-extended, with out_exc = 0.
REQ-032 Macro ALU_BITMANIP_EN undefined: opcodes 19-21 behave as illegal per REQ-018, and no count logic is synthesised.

Verification
REQ-033 ADD with a=0xFFFFFFFF, b=1, tag=5 into an empty FIFO, out_ready=1 -> next cycle out_valid=1, result=0x0, tag=5.
REQ-034 Hold out_ready=0 and issue 5 ADDs with DEPTH=4 -> in_ready drops after the 4th accept; the 4 results drain in order once out_ready=1.
REQ-035 BLT with a=-1, b=0, pred_taken=0, imm=0x100 -> br_valid pulse with taken=1, mispred=1, target=0x100; no out_valid.
REQ-036 FIFO holds sqn 3,4,5, then inv_valid with inv_sqn=3 -> only sqn 3 is written back; 4 and 5 are dropped silently.
REQ-037 CPOP a=0xF0F0F0F0 -> result 16 with ALU_BITMANIP_EN; result 0 with out_exc=1 without it.
REQ-038 rst pulsed while full with a branch pending -> next cycle out_valid=0, br_valid=0, in_ready=1.
